alu_mul_seq: RTL and testbench

Multi-cycle unsigned multiply sequencer that time-shares the core's single 16-bit combinational ALU. When idle it passes the core's ALU request through unchanged. When a multiply starts, it takes ownership of the ALU and runs a shift-add loop using ALU ADD and LSL operations. It asserts `busy` to stall the core and delivers the low 16 bits of the product with a one-cycle `done` pulse. It sits between the execute-stage operand muxes and the ALU's `busA`/`busB`/`ALUop` inputs.

---
 rtl/alu_mul_seq.sv | 128 ++++++++++++
 tb/tb_alu_mul_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle unsigned 16x16 (low 16 bits) multiply sequencer.
// It borrows the core's single combinational ALU for ADD/LSL steps of a
// shift-add loop. When idle, it passes the core's ALU request through.
module alu_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] core_a,
    input  logic [15:0] core_b,
    input  logic [3:0]  core_op,
    input  logic        mul_start,
    input  logic [15:0] mul_a,
    input  logic [15:0] mul_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_LSL = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [15:0] r_mplier;
    logic [15:0] r_product;
    logic [15:0] w_mplier_shr;

    assign w_mplier_shr = r_mplier >> 1;
    assign product      = r_product;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus ALU ownership mux and status outputs.
    always_comb begin
        w_next = r_state;
        alu_a  = core_a;
        alu_b  = core_b;
        alu_op = core_op;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (mul_start) begin
                    w_next = (mul_b == '0) ? S_DONE : S_ADD;
                end
            end
            S_ADD: begin
                alu_a  = r_acc;
                alu_b  = r_mcand;
                alu_op = OP_ADD;
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                alu_a  = r_mcand;
                alu_b  = 16'd1;
                alu_op = OP_LSL;
                w_next = (w_mplier_shr == '0) ? S_DONE : S_ADD;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, accumulate, shift, and product load on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mul_start) begin
                        r_acc    <= '0;
                        r_mcand  <= mul_a;
                        r_mplier <= mul_b;
                        // Zero multiplier goes straight to DONE; the product is 0.
                        if (mul_b == '0) begin
                            r_product <= '0;
                        end
                    end
                end
                S_ADD: begin
                    if (r_mplier[0]) begin
                        r_acc <= alu_result;
                    end
                end
                S_SHIFT: begin
                    r_mcand  <= alu_result;
                    r_mplier <= w_mplier_shr;
                    // acc is not written in SHIFT, so it already holds the final sum.
                    if (w_mplier_shr == '0) begin
                        r_product <= r_acc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq: directed and random multiplies against an
// arithmetic reference (a*b mod 2^16, latency from multiplier's top bit).
module tb_alu_mul_seq;

    logic        clk;
    logic        rst_n;
    logic [15:0] core_a;
    logic [15:0] core_b;
    logic [3:0]  core_op;
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int unsigned checks;
    int unsigned failures;
    logic [15:0] model_product;

    alu_mul_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_op    (core_op),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .product    (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the core's combinational ALU.
    always_comb begin
        case (alu_op)
            4'b0100: alu_result = alu_a + alu_b;
            4'b0101: alu_result = alu_a - alu_b;
            4'b0110: alu_result = alu_a << alu_b[3:0];
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One multiply. glitch_k: cycle in which a stray start is pulsed (0 = none).
    // rst_k: cycle in which reset is asserted to abort the run (0 = none).
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input int glitch_k, input int rst_k);
        logic [15:0] exp_p;
        int          h;
        int          lat;
        exp_p = 16'(32'(a) * 32'(b));
        h = -1;
        for (int i = 0; i < 16; i++) if (b[i]) h = i;
        lat = (h < 0) ? 1 : 2 * (h + 1) + 1;

        core_op   = 4'b1111;
        core_a    = 16'($urandom);
        core_b    = 16'($urandom);
        mul_a     = a;
        mul_b     = b;
        mul_start = 1'b1;
        @(posedge clk);
        #1;
        mul_start = 1'b0;
        mul_a     = 16'($urandom);
        mul_b     = 16'($urandom);

        for (int k = 1; k <= lat; k++) begin
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_product", 32'(product), 32'd0);
                chk("abort_alu_a", 32'(alu_a), 32'(core_a));
                chk("abort_alu_op", 32'(alu_op), 32'(core_op));
                model_product = '0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            if (k == glitch_k) begin
                mul_start = 1'b1;
                mul_a     = 16'd7;
                mul_b     = 16'd7;
            end else if (k == glitch_k + 1) begin
                mul_start = 1'b0;
            end
            chk("busy", 32'(busy), 32'd1);
            chk("done", 32'(done), 32'(k == lat));
            chk("product", 32'(product), 32'((k >= lat) ? exp_p : model_product));
            if (k < lat) begin
                chk("alu_op", 32'(alu_op), (k % 2 == 1) ? 32'h4 : 32'h6);
            end else begin
                chk("done_pass_op", 32'(alu_op), 32'(core_op));
                chk("done_pass_a", 32'(alu_a), 32'(core_a));
            end
            if (k == 1 && lat > 1) begin
                chk("add1_alu_a", 32'(alu_a), 32'd0);
                chk("add1_alu_b", 32'(alu_b), 32'(a));
            end
            @(posedge clk);
            #1;
        end
        mul_start = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_product", 32'(product), 32'(exp_p));
        model_product = exp_p;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        model_product = '0;
        rst_n         = 1'b0;
        core_a        = '0;
        core_b        = '0;
        core_op       = '0;
        mul_start     = 1'b0;
        mul_a         = '0;
        mul_b         = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle passthrough.
        core_a  = 16'd10;
        core_b  = 16'd3;
        core_op = 4'b0101;
        #1;
        chk("pass_alu_a", 32'(alu_a), 32'd10);
        chk("pass_alu_b", 32'(alu_b), 32'd3);
        chk("pass_alu_op", 32'(alu_op), 32'h5);
        chk("pass_result", 32'(alu_result), 32'd7);
        chk("pass_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        run_mul(16'd3, 16'd5, 0, 0);
        run_mul(16'h1234, 16'h0000, 0, 0);
        run_mul(16'hFFFF, 16'hFFFF, 0, 0);
        run_mul(16'd3, 16'd5, 3, 0);
        run_mul(16'h00FF, 16'h0101, 0, 4);
        run_mul(16'h00FF, 16'h0101, 0, 0);
        run_mul(16'h8000, 16'h8000, 0, 0);
        run_mul(16'h0001, 16'h0001, 0, 0);

        for (int n = 0; n < 20; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 16);
            run_mul(ra, rb, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
